// File: rtl/i2c_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_arbiter_if
// Purpose  : Client-side request/response and I2C-master-side signal bundle
//            for the shared I2C master arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface i2c_bus_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_rd_wr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_nack;
  logic                      rsp_timeout;
  logic                      m_on;
  logic [ADDR_W-1:0]         m_addr;
  logic                      m_rd_wr;
  logic [DATA_W-1:0]         m_wdata;
  logic                      m_abort;
  logic                      m_done;
  logic                      m_nack;
  logic [DATA_W-1:0]         m_rdata;

  // The arbiter itself sits on the slave side of this bundle.
  modport slave (
    input  req, req_addr, req_rd_wr, req_wdata, m_done, m_nack, m_rdata,
    output gnt, done, rsp_rdata, rsp_nack, rsp_timeout,
           m_on, m_addr, m_rd_wr, m_wdata, m_abort
  );

  modport master (
    output req, req_addr, req_rd_wr, req_wdata, m_done, m_nack, m_rdata,
    input  gnt, done, rsp_rdata, rsp_nack, rsp_timeout,
           m_on, m_addr, m_rd_wr, m_wdata, m_abort
  );
endinterface
`default_nettype wire

// File: rtl/i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_arbiter
// Purpose  : Round-robin arbiter sharing one I2C master FSM among NUM_REQ
//            clients. Optional BUSY watchdog: define I2C_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_bus_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  wire logic        clk,
  input  wire logic        reset,
  i2c_bus_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GRANT  = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_BUSY   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic [PTR_W-1:0]   sel_idx;
  logic [PTR_W:0]     cand;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] win_onehot;
  logic               m_on_q, m_on_d;
  logic [ADDR_W-1:0]  m_addr_q, m_addr_d;
  logic               m_rd_wr_q, m_rd_wr_d;
  logic [DATA_W-1:0]  m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_nack_q, rsp_nack_d;
  logic               tmo_hit;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = bus.req_wdata[g*DATA_W +: DATA_W];
  end

  assign win_onehot = NUM_REQ'(1) << win_q;

  // Scan downward so the lowest offset from rr_ptr is the last (winning) write.
  always_comb begin
    sel_idx = rr_ptr_q;
    cand    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W + 1)'(i);
      if (cand >= (PTR_W + 1)'(NUM_REQ)) cand = cand - (PTR_W + 1)'(NUM_REQ);
      if (bus.req[cand[PTR_W-1:0]]) sel_idx = cand[PTR_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (|bus.req) state_d = S_GRANT;
      S_GRANT:  state_d = bus.req[win_q] ? S_LAUNCH : S_IDLE;
      S_LAUNCH: state_d = S_BUSY;
      S_BUSY:   if (bus.m_done || tmo_hit) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    win_d       = win_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    m_on_d      = 1'b0;
    m_addr_d    = m_addr_q;
    m_rd_wr_d   = m_rd_wr_q;
    m_wdata_d   = m_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_nack_d  = rsp_nack_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          win_d = sel_idx;
          gnt_d = NUM_REQ'(1) << sel_idx;
        end
      end
      S_GRANT: begin
        if (bus.req[win_q]) begin
          m_addr_d  = addr_arr[win_q];
          m_rd_wr_d = bus.req_rd_wr[win_q];
          m_wdata_d = wdata_arr[win_q];
          m_on_d    = 1'b1;
        end else begin
          gnt_d = '0;
        end
      end
      S_BUSY: begin
        if (bus.m_done) begin
          rsp_rdata_d = bus.m_rdata;
          rsp_nack_d  = bus.m_nack;
          done_d      = win_onehot;
        end else if (tmo_hit) begin
          rsp_rdata_d = '0;
          rsp_nack_d  = 1'b1;
          done_d      = win_onehot;
        end
      end
      S_RESP: begin
        rr_ptr_d = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
        gnt_d    = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      win_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      m_on_q      <= 1'b0;
      m_addr_q    <= '0;
      m_rd_wr_q   <= 1'b0;
      m_wdata_q   <= '0;
      rsp_rdata_q <= '0;
      rsp_nack_q  <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      win_q       <= win_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      m_on_q      <= m_on_d;
      m_addr_q    <= m_addr_d;
      m_rd_wr_q   <= m_rd_wr_d;
      m_wdata_q   <= m_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_nack_q  <= rsp_nack_d;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             m_abort_q, m_abort_d;
  logic             rsp_timeout_q, rsp_timeout_d;

  // Fires on the cycle whose increment would bring the count to TIMEOUT_CYC-1;
  // a simultaneous m_done takes precedence.
  assign tmo_hit = (state_q == S_BUSY) && !bus.m_done &&
                   (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 2));

  always_comb begin
    tmo_cnt_d     = tmo_cnt_q;
    m_abort_d     = tmo_hit;
    rsp_timeout_d = rsp_timeout_q;
    if (state_q == S_LAUNCH) begin
      tmo_cnt_d = '0;
    end else if (state_q == S_BUSY) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
      if (bus.m_done)   rsp_timeout_d = 1'b0;
      else if (tmo_hit) rsp_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q     <= '0;
      m_abort_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      m_abort_q     <= m_abort_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.m_abort     = m_abort_q;
  assign bus.rsp_timeout = rsp_timeout_q;
`else
  localparam int TIMEOUT_CYC_unused = TIMEOUT_CYC;

  assign tmo_hit         = 1'b0;
  assign bus.m_abort     = 1'b0;
  assign bus.rsp_timeout = 1'b0;
`endif

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.m_on      = m_on_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_rd_wr   = m_rd_wr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_nack  = rsp_nack_q;
endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_bus_arbiter
// Purpose  : Directed self-checking bench for i2c_bus_arbiter with a response
//            scoreboard; covers I2C_ARB_TIMEOUT_EN when that macro is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_bus_arbiter;
  localparam int NR  = 4;
  localparam int AW  = 7;
  localparam int DW  = 8;
  localparam int TMO = 16;

  typedef struct {
    logic [NR-1:0] done;
    logic [DW-1:0] rdata;
    logic          nack;
    logic          tmo;
  } exp_t;

  exp_t sb[$];
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  i2c_bus_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  i2c_bus_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_gnt"},         32'(bus.gnt),         0);
    chk({pfx, "_done"},        32'(bus.done),        0);
    chk({pfx, "_m_on"},        32'(bus.m_on),        0);
    chk({pfx, "_m_abort"},     32'(bus.m_abort),     0);
    chk({pfx, "_m_addr"},      32'(bus.m_addr),      0);
    chk({pfx, "_m_rd_wr"},     32'(bus.m_rd_wr),     0);
    chk({pfx, "_m_wdata"},     32'(bus.m_wdata),     0);
    chk({pfx, "_rsp_rdata"},   32'(bus.rsp_rdata),   0);
    chk({pfx, "_rsp_nack"},    32'(bus.rsp_nack),    0);
    chk({pfx, "_rsp_timeout"}, 32'(bus.rsp_timeout), 0);
  endtask

  task automatic set_req(input int w, input logic [AW-1:0] a, input logic rd, input logic [DW-1:0] wd);
    bus.req_addr[w*AW +: AW]  = a;
    bus.req_wdata[w*DW +: DW] = wd;
    bus.req_rd_wr[w]          = rd;
    bus.req[w]                = 1'b1;
  endtask

  // Called at the negedge where the request is visible and the DUT is IDLE;
  // returns at the first BUSY negedge.
  task automatic start_txn(input int w, input logic [AW-1:0] a, input logic rd, input logic [DW-1:0] wd);
    @(negedge clk);
    chk("gnt", 32'(bus.gnt), 32'(1) << w);
    chk("m_on_early", 32'(bus.m_on), 0);
    @(negedge clk);
    chk("m_on", 32'(bus.m_on), 1);
    chk("m_addr", 32'(bus.m_addr), 32'(a));
    chk("m_rd_wr", 32'(bus.m_rd_wr), 32'(rd));
    chk("m_wdata", 32'(bus.m_wdata), 32'(wd));
    @(negedge clk);
    chk("m_on_pulse", 32'(bus.m_on), 0);
    chk("gnt_busy", 32'(bus.gnt), 32'(1) << w);
  endtask

  task automatic wait_done(input int max_wait, input int exp_lat);
    exp_t e;
    int   k;
    k = 0;
    do begin
      @(negedge clk);
      bus.m_done = 1'b0;
      k++;
    end while (bus.done == '0 && k < max_wait);
    if (bus.done == '0) begin
      n_tests++;
      n_fail++;
      $error("FAIL done_wait: no done within %0d cycles", max_wait);
    end else if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL sb_underflow: done=0x%0h with nothing expected", bus.done);
    end else begin
      e = sb.pop_front();
      chk("done", 32'(bus.done), 32'(e.done));
      chk("done_latency", 32'(k), 32'(exp_lat));
      chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
      chk("rsp_nack", 32'(bus.rsp_nack), 32'(e.nack));
      chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.tmo));
      chk("m_abort", 32'(bus.m_abort), 32'(e.tmo));
      chk("gnt_resp", 32'(bus.gnt), 32'(e.done));
    end
    @(negedge clk);
    chk("gnt_idle", 32'(bus.gnt), 0);
    chk("done_pulse", 32'(bus.done), 0);
  endtask

  task automatic finish_txn(input int w, input logic [DW-1:0] rd, input logic nk);
    exp_t e;
    bus.m_done  = 1'b1;
    bus.m_rdata = rd;
    bus.m_nack  = nk;
    e.done = NR'(1) << w;
    e.rdata = rd;
    e.nack = nk;
    e.tmo = 1'b0;
    sb.push_back(e);
    wait_done(8, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.req       = '0;
    bus.req_addr  = '0;
    bus.req_rd_wr = '0;
    bus.req_wdata = '0;
    bus.m_done    = 1'b0;
    bus.m_nack    = 1'b0;
    bus.m_rdata   = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    reset = 1'b0;

    // Round-robin with all four held: 0,1,2,3,0.
    for (int i = 0; i < NR; i++) set_req(i, AW'(16 + i), i[0], DW'(128 + i));
    for (int i = 0; i < 5; i++) begin
      start_txn(i % NR, AW'(16 + i % NR), i[0], DW'(128 + i % NR));
      finish_txn(i % NR, DW'(64 + i), 1'b0);
    end
    bus.req = '0;

    // Single read by requester 1.
    set_req(1, 7'h50, 1'b1, 8'h00);
    start_txn(1, 7'h50, 1'b1, 8'h00);
    finish_txn(1, 8'hA5, 1'b0);
    bus.req = '0;

    // NACKed write by requester 2.
    set_req(2, 7'h22, 1'b0, 8'h3C);
    start_txn(2, 7'h22, 1'b0, 8'h3C);
    finish_txn(2, 8'h5A, 1'b1);
    bus.req = '0;

    // Cancel in GRANT: rr_ptr stays at 3, so 3 beats 0 afterwards.
    set_req(3, 7'h33, 1'b0, 8'h99);
    @(negedge clk);
    chk("cancel_gnt", 32'(bus.gnt), 32'h8);
    bus.req[3] = 1'b0;
    @(negedge clk);
    chk("cancel_gnt_clr", 32'(bus.gnt), 0);
    chk("cancel_no_m_on", 32'(bus.m_on), 0);
    @(negedge clk);
    chk("cancel_no_m_on2", 32'(bus.m_on), 0);
    set_req(0, 7'h0A, 1'b1, 8'h01);
    set_req(3, 7'h3B, 1'b0, 8'hC3);
    start_txn(3, 7'h3B, 1'b0, 8'hC3);
    finish_txn(3, 8'h11, 1'b0);
    bus.req[3] = 1'b0;
    start_txn(0, 7'h0A, 1'b1, 8'h01);
    finish_txn(0, 8'h77, 1'b0);
    bus.req = '0;

    // Stray m_done in IDLE must be ignored.
    bus.m_done  = 1'b1;
    bus.m_rdata = 8'hFF;
    bus.m_nack  = 1'b1;
    @(negedge clk);
    bus.m_done = 1'b0;
    @(negedge clk);
    chk("stray_done", 32'(bus.done), 0);
    chk("stray_gnt", 32'(bus.gnt), 0);
    chk("stray_rdata_held", 32'(bus.rsp_rdata), 32'h77);
    chk("stray_nack_held", 32'(bus.rsp_nack), 0);

    // Master never completes.
    set_req(2, 7'h11, 1'b1, 8'h00);
    start_txn(2, 7'h11, 1'b1, 8'h00);
`ifdef I2C_ARB_TIMEOUT_EN
    begin
      exp_t e;
      repeat (14) @(negedge clk);
      chk("tmo_abort_early", 32'(bus.m_abort), 0);
      chk("tmo_done_early", 32'(bus.done), 0);
      e.done = 4'b0100;
      e.rdata = 8'h00;
      e.nack = 1'b1;
      e.tmo = 1'b1;
      sb.push_back(e);
      wait_done(4, 1);
      start_txn(2, 7'h11, 1'b1, 8'h00);
    end
`else
    repeat (40) @(negedge clk);
    chk("hang_gnt", 32'(bus.gnt), 32'h4);
    chk("hang_abort", 32'(bus.m_abort), 0);
    chk("hang_done", 32'(bus.done), 0);
`endif

    // Asynchronous reset while BUSY, then restart from rr_ptr 0.
    bus.req = '0;
    #2 reset = 1'b1;
    #1 chk_reset_outputs("arst");
    @(negedge clk);
    reset = 1'b0;
    set_req(0, 7'h2D, 1'b0, 8'hE1);
    set_req(2, 7'h4E, 1'b1, 8'h00);
    start_txn(0, 7'h2D, 1'b0, 8'hE1);
    finish_txn(0, 8'h3D, 1'b0);
    bus.req[0] = 1'b0;
    start_txn(2, 7'h4E, 1'b1, 8'h00);
    finish_txn(2, 8'hC8, 1'b1);
    bus.req = '0;

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL sb_leftover: %0d expected responses never seen", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
